// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a transmit FIFO. Frame format (data bits,
// parity mode, stop bits) is latched per frame when the head word is popped.
module uart_tx_cfg #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_txclken,
  input  logic [3:0]               i_nbits,
  input  logic [1:0]               i_parity,
  input  logic                     i_stop2,
  input  logic                     i_valid,
  input  logic [DATA_W-1:0]        i_txdata,
  output logic                     o_ready,
  input  logic                     i_clear,
  output logic                     o_tx,
  output logic                     o_busy,
  output logic                     o_txdone,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]       level_q, level_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          nbits_q, nbits_d;
  logic                par_en_q, par_en_d;
  logic                par_q, par_d;
  logic                stop2_q, stop2_d;
  logic                tx_q, tx_d;
  logic                txdone_q, txdone_d;

  logic                full, empty, push, pop, load, fin;
  logic [3:0]          nbits_eff;
  logic [DATA_W-1:0]   head;
  logic                head_par;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign push    = i_valid & ~full;
  assign head    = mem_q[rd_ptr_q];
  assign o_ready = ~full;
  assign o_level = level_q;
  assign o_tx    = tx_q;
  assign o_busy  = (state_q != StIdle);
  assign o_txdone = txdone_q;

  always_comb begin
    nbits_eff = i_nbits;
    if (i_nbits < 4'd5) begin
      nbits_eff = 4'd5;
    end else if (i_nbits > 4'(DATA_W)) begin
      nbits_eff = 4'(DATA_W);
    end
  end

  // Parity over only the bits that will actually be sent.
  always_comb begin
    head_par = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (4'(i) < nbits_eff) begin
        head_par = head_par ^ head[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    nbits_d  = nbits_q;
    par_en_d = par_en_q;
    par_d    = par_q;
    stop2_d  = stop2_q;
    tx_d     = tx_q;
    txdone_d = 1'b0;
    load     = 1'b0;
    fin      = 1'b0;
    pop      = 1'b0;

    if (i_txclken) begin
      case (state_q)
        StIdle: load = ~empty;
        StStart: begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = 4'd1;
          state_d = StData;
        end
        StData: begin
          if (cnt_q < nbits_q) begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 4'd1;
          end else if (par_en_q) begin
            tx_d    = par_q;
            state_d = StParity;
          end else begin
            tx_d    = 1'b1;
            state_d = StStop1;
          end
        end
        StParity: begin
          tx_d    = 1'b1;
          state_d = StStop1;
        end
        StStop1: begin
          if (stop2_q) begin
            state_d = StStop2;
          end else begin
            fin = 1'b1;
          end
        end
        StStop2: fin = 1'b1;
        default: state_d = StIdle;
      endcase

      if (fin) begin
        txdone_d = 1'b1;
        load     = ~empty;
        tx_d     = 1'b1;
        state_d  = StIdle;
      end

      // Back-to-back frames start straight from the stop bit with no idle gap.
      if (load) begin
        pop      = 1'b1;
        shift_d  = head;
        nbits_d  = nbits_eff;
        par_en_d = (i_parity == 2'b01) || (i_parity == 2'b10);
        par_d    = head_par ^ (i_parity == 2'b10);
        stop2_d  = i_stop2;
        tx_d     = 1'b0;
        state_d  = StStart;
      end
    end
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!push && pop) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && i_reset_n && !i_clear) begin
      mem_q[wr_ptr_q] <= i_txdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q  <= StIdle;
      tx_q     <= 1'b1;
      txdone_q <= 1'b0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      shift_q  <= '0;
      cnt_q    <= '0;
      nbits_q  <= 4'd8;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop2_q  <= 1'b0;
    end else if (i_clear) begin
      state_q  <= StIdle;
      tx_q     <= 1'b1;
      txdone_q <= 1'b0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      txdone_q <= txdone_d;
      level_q  <= level_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      nbits_q  <= nbits_d;
      par_en_q <= par_en_d;
      par_q    <= par_d;
      stop2_q  <= stop2_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

endmodule
